// File: rtl/a_wb_pkg.sv
// ============================================================================
// Module      : a_wb_pkg
// Description : Shared constants for the A-result writeback slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package a_wb_pkg;

    localparam int AW_DEFAULT = 24;
    localparam int NREG       = 8;
    localparam int SRC_W      = 4;

    localparam logic [SRC_W-1:0] SRC_IMM = 4'd0;
    localparam logic [SRC_W-1:0] SRC_S   = 4'd1;
    localparam logic [SRC_W-1:0] SRC_ADD = 4'd2;
    localparam logic [SRC_W-1:0] SRC_MUL = 4'd3;
    localparam logic [SRC_W-1:0] SRC_POP = 4'd4;
    localparam logic [SRC_W-1:0] SRC_MEM = 4'd5;
    localparam logic [SRC_W-1:0] SRC_B   = 4'd6;

    function automatic logic src_defined(input logic [SRC_W-1:0] src);
        return (src <= SRC_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/a_result_writeback_if.sv
// ============================================================================
// Module      : a_result_writeback_if
// Description : Result-bus, operand and read-port bundle for A writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface a_result_writeback_if #(
    parameter int AW = 24
);
    logic          i_cip_vld;
    logic          i_result_en;
    logic [3:0]    i_result_src;
    logic [2:0]    i_result_dest;
    logic [AW-1:0] i_imm;
    logic [AW-1:0] i_s_data;
    logic [AW-1:0] i_add_res;
    logic [AW-1:0] i_mul_res;
    logic [AW-1:0] i_pop_res;
    logic [AW-1:0] i_b_data;
    logic [AW-1:0] i_mem_data;
    logic          i_mem_vld;
    logic [2:0]    i_rd_i;
    logic [2:0]    i_rd_j;
    logic [2:0]    i_rd_k;
    logic [AW-1:0] o_a_i;
    logic [AW-1:0] o_a_j;
    logic [AW-1:0] o_a_k;
    logic [AW-1:0] o_a0;
    logic [1:0]    o_hold_cnt;
    logic          o_err_src;
    logic          o_err_mem;

    modport master (
        output i_cip_vld, i_result_en, i_result_src, i_result_dest,
               i_imm, i_s_data, i_add_res, i_mul_res, i_pop_res, i_b_data,
               i_mem_data, i_mem_vld, i_rd_i, i_rd_j, i_rd_k,
        input  o_a_i, o_a_j, o_a_k, o_a0, o_hold_cnt, o_err_src, o_err_mem
    );

    modport slave (
        input  i_cip_vld, i_result_en, i_result_src, i_result_dest,
               i_imm, i_s_data, i_add_res, i_mul_res, i_pop_res, i_b_data,
               i_mem_data, i_mem_vld, i_rd_i, i_rd_j, i_rd_k,
        output o_a_i, o_a_j, o_a_k, o_a0, o_hold_cnt, o_err_src, o_err_mem
    );

endinterface

`default_nettype wire

// File: rtl/a_hold_fifo.sv
// ============================================================================
// Module      : a_hold_fifo
// Description : 2-entry shift FIFO holding early memory loads until commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a_hold_fifo #(
    parameter int AW = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          push_i,
    input  wire logic [AW-1:0] push_data_i,
    input  wire logic          pop_i,
    output logic      [AW-1:0] pop_data_o,
    output logic      [1:0]    count_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    logic [AW-1:0] mem_q [2];
    logic [1:0]    count_q;

    // Entry 0 is always the head; an empty pop returns zero.
    assign pop_data_o  = (count_q != 2'd0) ? mem_q[0] : '0;
    assign count_o     = count_q;
    assign overflow_o  = push_i && !pop_i && (count_q == 2'd2);
    assign underflow_o = pop_i && (count_q == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i) begin
                        mem_q[0] <= push_data_i;
                        count_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        mem_q[0] <= push_data_i;
                    end else if (push_i) begin
                        mem_q[1] <= push_data_i;
                        count_q  <= 2'd2;
                    end else if (pop_i) begin
                        count_q  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (push_i && pop_i) begin
                        mem_q[0] <= mem_q[1];
                        mem_q[1] <= push_data_i;
                    end else if (pop_i) begin
                        mem_q[0] <= mem_q[1];
                        count_q  <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/a_result_writeback.sv
// ============================================================================
// Module      : a_result_writeback
// Description : A-register file writeback from the scheduled result bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a_result_writeback
    import a_wb_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    a_result_writeback_if.slave bus
);

    logic [AW-1:0] a_q [NREG];
    logic          err_src_q;
    logic          err_mem_q;

    logic          w_commit;
    logic          w_mem_pop;
    logic [AW-1:0] w_fifo_head;
    logic [AW-1:0] w_wdata;
    logic          w_overflow;
    logic          w_underflow;

    assign w_commit  = bus.i_result_en && bus.i_cip_vld;
    assign w_mem_pop = w_commit && (bus.i_result_src == SRC_MEM);

    a_hold_fifo #(
        .AW (AW)
    ) u_hold_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.i_mem_vld),
        .push_data_i (bus.i_mem_data),
        .pop_i       (w_mem_pop),
        .pop_data_o  (w_fifo_head),
        .count_o     (bus.o_hold_cnt),
        .overflow_o  (w_overflow),
        .underflow_o (w_underflow)
    );

    always_comb begin
        w_wdata = '0;
        case (bus.i_result_src)
            SRC_IMM: w_wdata = bus.i_imm;
            SRC_S:   w_wdata = bus.i_s_data;
            SRC_ADD: w_wdata = bus.i_add_res;
            SRC_MUL: w_wdata = bus.i_mul_res;
            SRC_POP: w_wdata = bus.i_pop_res;
            SRC_MEM: w_wdata = w_fifo_head;
            SRC_B:   w_wdata = bus.i_b_data;
            default: w_wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                a_q[r] <= '0;
            end
            err_src_q <= 1'b0;
            err_mem_q <= 1'b0;
        end else begin
            if (w_commit) begin
                a_q[bus.i_result_dest] <= w_wdata;
            end
            if (w_commit && !src_defined(bus.i_result_src)) begin
                err_src_q <= 1'b1;
            end
            if (w_overflow || w_underflow) begin
                err_mem_q <= 1'b1;
            end
        end
    end

    // Write-first bypass: a committing write is visible on matching read ports now.
    always_comb begin
        bus.o_a_i = a_q[bus.i_rd_i];
        bus.o_a_j = a_q[bus.i_rd_j];
        bus.o_a_k = a_q[bus.i_rd_k];
        bus.o_a0  = a_q[0];
        if (w_commit && (bus.i_result_dest == bus.i_rd_i)) bus.o_a_i = w_wdata;
        if (w_commit && (bus.i_result_dest == bus.i_rd_j)) bus.o_a_j = w_wdata;
        if (w_commit && (bus.i_result_dest == bus.i_rd_k)) bus.o_a_k = w_wdata;
        if (w_commit && (bus.i_result_dest == 3'd0))       bus.o_a0  = w_wdata;
    end

    assign bus.o_err_src = err_src_q;
    assign bus.o_err_mem = err_mem_q;

endmodule

`default_nettype wire

// File: tb/tb_a_result_writeback.sv
// ============================================================================
// Module      : tb_a_result_writeback
// Description : Directed self-checking bench for the A-result writeback block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a_result_writeback;
    import a_wb_pkg::*;

    localparam int C_AW = 24;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    a_result_writeback_if #(.AW(C_AW)) bus ();

    a_result_writeback #(
        .AW (C_AW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [C_AW-1:0] obs, input logic [C_AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_result_en = 1'b0;
        bus.i_cip_vld   = 1'b0;
        bus.i_mem_vld   = 1'b0;
    endtask

    task automatic commit(input logic [3:0] src, input logic [2:0] dest);
        bus.i_result_en   = 1'b1;
        bus.i_cip_vld     = 1'b1;
        bus.i_result_src  = src;
        bus.i_result_dest = dest;
    endtask

    task automatic push(input logic [C_AW-1:0] d);
        bus.i_mem_vld  = 1'b1;
        bus.i_mem_data = d;
    endtask

    // Reads register r through port i with no write in flight.
    task automatic read_reg(input logic [2:0] r, output logic [C_AW-1:0] v);
        bus.i_rd_i = r;
        #1;
        v = bus.o_a_i;
    endtask

    initial begin
        logic [C_AW-1:0] v;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.i_cip_vld = 1'b0;   bus.i_result_en = 1'b0;
        bus.i_result_src = 4'd0; bus.i_result_dest = 3'd0;
        bus.i_imm = '0;     bus.i_s_data = '0;  bus.i_add_res = '0;
        bus.i_mul_res = '0; bus.i_pop_res = '0; bus.i_b_data = '0;
        bus.i_mem_data = '0; bus.i_mem_vld = 1'b0;
        bus.i_rd_i = 3'd0; bus.i_rd_j = 3'd0; bus.i_rd_k = 3'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], v);
            check($sformatf("reset_A%0d", r), v, 24'h0);
        end
        check("reset_cnt", {22'd0, bus.o_hold_cnt}, 24'd0);
        check("reset_err_src", {23'd0, bus.o_err_src}, 24'd0);
        check("reset_err_mem", {23'd0, bus.o_err_mem}, 24'd0);

        // IMM to A3 with same-cycle bypass
        bus.i_rd_i = 3'd3; bus.i_rd_j = 3'd4;
        bus.i_imm = 24'h001234;
        commit(SRC_IMM, 3'd3);
        #1;
        check("imm_bypass", bus.o_a_i, 24'h001234);
        check("imm_other_bypass", bus.o_a_j, 24'h0);
        tick(); idle(); #1;
        check("imm_hold", bus.o_a_i, 24'h001234);
        check("imm_a0", bus.o_a0, 24'h0);

        // ADD to A5 stalled by i_cip_vld
        bus.i_rd_k = 3'd5;
        bus.i_add_res = 24'hABCDEF;
        bus.i_result_en = 1'b1; bus.i_cip_vld = 1'b0;
        bus.i_result_src = SRC_ADD; bus.i_result_dest = 3'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_bypass_%0d", c), bus.o_a_k, 24'h0);
            tick();
            check($sformatf("stall_hold_%0d", c), bus.o_a_k, 24'h0);
        end
        bus.i_cip_vld = 1'b1;
        #1;
        check("add_bypass", bus.o_a_k, 24'hABCDEF);
        tick();
        bus.i_cip_vld = 1'b0;
        bus.i_add_res = 24'h555555;
        tick(); #1;
        check("add_once", bus.o_a_k, 24'hABCDEF);
        idle();

        // Two buffered loads committed in order
        push(24'h000011); tick();
        check("fifo_cnt_1", {22'd0, bus.o_hold_cnt}, 24'd1);
        push(24'h000022); tick(); idle();
        check("fifo_cnt_2", {22'd0, bus.o_hold_cnt}, 24'd2);
        bus.i_rd_i = 3'd1;
        commit(SRC_MEM, 3'd1);
        #1;
        check("mem_bypass_A1", bus.o_a_i, 24'h000011);
        tick();
        check("fifo_cnt_pop1", {22'd0, bus.o_hold_cnt}, 24'd1);
        commit(SRC_MEM, 3'd2);
        tick(); idle();
        check("fifo_cnt_pop2", {22'd0, bus.o_hold_cnt}, 24'd0);
        read_reg(3'd1, v); check("mem_A1", v, 24'h000011);
        read_reg(3'd2, v); check("mem_A2", v, 24'h000022);
        check("mem_no_err", {23'd0, bus.o_err_mem}, 24'd0);

        // Push and pop together while full
        push(24'h000033); tick();
        push(24'h000044); tick();
        push(24'h000055); commit(SRC_MEM, 3'd6); tick(); idle();
        check("full_pp_cnt", {22'd0, bus.o_hold_cnt}, 24'd2);
        read_reg(3'd6, v); check("full_pp_A6", v, 24'h000033);
        commit(SRC_MEM, 3'd7); tick(); idle();
        read_reg(3'd7, v); check("full_pp_A7", v, 24'h000044);
        commit(SRC_MEM, 3'd4); tick(); idle();
        read_reg(3'd4, v); check("full_pp_A4", v, 24'h000055);
        check("full_pp_cnt_end", {22'd0, bus.o_hold_cnt}, 24'd0);
        check("full_pp_no_err", {23'd0, bus.o_err_mem}, 24'd0);

        // Overflow: third push lost
        push(24'h000066); tick();
        push(24'h000077); tick();
        push(24'h000088); tick(); idle();
        check("ovf_cnt", {22'd0, bus.o_hold_cnt}, 24'd2);
        check("ovf_err", {23'd0, bus.o_err_mem}, 24'd1);
        commit(SRC_MEM, 3'd6); tick();
        commit(SRC_MEM, 3'd7); tick(); idle();
        read_reg(3'd6, v); check("ovf_A6", v, 24'h000066);
        read_reg(3'd7, v); check("ovf_A7", v, 24'h000077);
        check("ovf_cnt_empty", {22'd0, bus.o_hold_cnt}, 24'd0);

        // Reset mid-stream with a write and a push in the same cycle
        push(24'h000099); tick(); idle();
        bus.i_imm = 24'hFFFFFF;
        commit(SRC_IMM, 3'd3);
        push(24'h0000AA);
        rst = 1'b1; tick(); rst = 1'b0; idle();
        check("rst_cnt", {22'd0, bus.o_hold_cnt}, 24'd0);
        check("rst_err_mem", {23'd0, bus.o_err_mem}, 24'd0);
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], v);
            check($sformatf("rst_A%0d", r), v, 24'h0);
        end

        // Undefined source code
        bus.i_imm = 24'h000ABC;
        commit(SRC_IMM, 3'd0); tick(); idle(); #1;
        check("a0_pre", bus.o_a0, 24'h000ABC);
        commit(4'd9, 3'd0);
        #1;
        check("undef_bypass_a0", bus.o_a0, 24'h0);
        tick(); idle(); #1;
        check("undef_a0", bus.o_a0, 24'h0);
        check("undef_err_src", {23'd0, bus.o_err_src}, 24'd1);
        commit(SRC_IMM, 3'd1); tick(); idle();
        check("undef_err_sticky", {23'd0, bus.o_err_src}, 24'd1);
        check("undef_no_err_mem", {23'd0, bus.o_err_mem}, 24'd0);

        // Pop from empty FIFO
        bus.i_imm = 24'h000777;
        commit(SRC_IMM, 3'd5); tick(); idle();
        commit(SRC_MEM, 3'd5); tick(); idle();
        read_reg(3'd5, v); check("udf_A5", v, 24'h0);
        check("udf_err_mem", {23'd0, bus.o_err_mem}, 24'd1);

        // Pop from empty with same-cycle push: zero written, push kept
        bus.i_imm = 24'h000123;
        commit(SRC_IMM, 3'd4); tick(); idle();
        commit(SRC_MEM, 3'd4); push(24'h0000BB); tick(); idle();
        read_reg(3'd4, v); check("udf_push_A4", v, 24'h0);
        check("udf_push_cnt", {22'd0, bus.o_hold_cnt}, 24'd1);
        commit(SRC_MEM, 3'd4); tick(); idle();
        read_reg(3'd4, v); check("udf_push_kept", v, 24'h0000BB);
        check("udf_err_sticky", {23'd0, bus.o_err_mem}, 24'd1);

        // Remaining sources through the bus
        bus.i_s_data = 24'h5A5A5A; bus.i_mul_res = 24'h0F0F0F;
        bus.i_pop_res = 24'h000017; bus.i_b_data = 24'hC0FFEE;
        commit(SRC_S, 3'd1);   tick();
        commit(SRC_MUL, 3'd2); tick();
        commit(SRC_POP, 3'd3); tick();
        commit(SRC_B, 3'd6);   tick(); idle();
        read_reg(3'd1, v); check("src_S", v, 24'h5A5A5A);
        read_reg(3'd2, v); check("src_MUL", v, 24'h0F0F0F);
        read_reg(3'd3, v); check("src_POP", v, 24'h000017);
        read_reg(3'd6, v); check("src_B", v, 24'hC0FFEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
